trng_word_arbiter: RTL and testbench

Sequencer and arbiter for the `trng_parallel32` word generator. It resets and seeds the generator, discards output during a warm-up interval, and buffers valid random words in a small FIFO. It then shares those words among `NUM_REQ` consumers with round-robin arbitration. It sits between `trng_parallel32` and the crypto/nonce clients, and is the only block allowed to drive the generator's reset and seed inputs.

---
 rtl/trng_ctrl_pkg.sv | 26 ++
 rtl/trng_word_arbiter_if.sv | 43 ++++
 rtl/trng_word_fifo.sv | 58 +++++
 rtl/trng_word_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_trng_word_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/trng_ctrl_pkg.sv
// trng_ctrl_pkg
// Shared types and constants for the trng_parallel32 sequencer/arbiter.
//   trng_ctrl_state_e : sequencer states (ST_FAULT exists only with TRNG_HEALTH_EN)
//   TRNG_WORD_W       : generator word width
//   TRNG_D3_W         : width of the generator's d3 seed input
//   SEED_*_DEFAULT    : default seed constants driven to the generator
// Optional feature macro: TRNG_HEALTH_EN (adds the fault state).
package trng_ctrl_pkg;

  localparam int TRNG_WORD_W = 32;
  localparam int TRNG_D3_W   = 5;

  localparam logic [TRNG_WORD_W-1:0] SEED_D1_DEFAULT = 32'hAAAAAAAA;
  localparam logic [TRNG_WORD_W-1:0] SEED_D2_DEFAULT = 32'h55555555;
  localparam logic [TRNG_D3_W-1:0]   SEED_D3_DEFAULT = 5'b10101;

  typedef enum logic [1:0] {
    ST_TRNG_RST = 2'd0,
    ST_WARMUP   = 2'd1,
    ST_RUN      = 2'd2
`ifdef TRNG_HEALTH_EN
    , ST_FAULT  = 2'd3
`endif
  } trng_ctrl_state_e;

endpackage

// File: rtl/trng_word_arbiter_if.sv
// trng_word_arbiter_if
// Bundles the generator-side and consumer-side signals of trng_word_arbiter.
//   master : the arbiter (drives generator reset/seeds, grants, read data, status)
//   slave  : the environment (generator word stream and consumer requests)
// Signals:
//   trng_rst, trng_d1, trng_d2, trng_d3     generator reset and seeds
//   trng_word_valid, trng_rand_word         generator word stream
//   req / gnt                               per-consumer request / one-hot grant
//   rdata                                   FIFO head, valid while any gnt bit is set
//   ready, fifo_level, drop_cnt, fault      status
interface trng_word_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 4
);
  import trng_ctrl_pkg::*;

  logic                           trng_rst;
  logic [TRNG_WORD_W-1:0]         trng_d1;
  logic [TRNG_WORD_W-1:0]         trng_d2;
  logic [TRNG_D3_W-1:0]           trng_d3;
  logic                           trng_word_valid;
  logic [TRNG_WORD_W-1:0]         trng_rand_word;
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0]             gnt;
  logic [TRNG_WORD_W-1:0]         rdata;
  logic                           ready;
  logic [$clog2(FIFO_DEPTH):0]    fifo_level;
  logic [15:0]                    drop_cnt;
  logic                           fault;

  modport master (
    output trng_rst, trng_d1, trng_d2, trng_d3,
    output gnt, rdata, ready, fifo_level, drop_cnt, fault,
    input  trng_word_valid, trng_rand_word, req
  );

  modport slave (
    input  trng_rst, trng_d1, trng_d2, trng_d3,
    input  gnt, rdata, ready, fifo_level, drop_cnt, fault,
    output trng_word_valid, trng_rand_word, req
  );

endinterface

// File: rtl/trng_word_fifo.sv
// trng_word_fifo
// Synchronous word FIFO. Pointers carry one extra MSB so full and empty are
// distinguished without a separate counter.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_push        write i_data at the tail (caller never pushes into a full
//                 FIFO unless it pops in the same cycle)
//   i_pop         advance the head (caller never pops an empty FIFO)
//   i_flush       discard all contents (priority over push/pop)
//   o_full, o_empty, o_level, o_head
module trng_word_fifo
  import trng_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [TRNG_WORD_W-1:0]   i_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [TRNG_WORD_W-1:0]   o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [TRNG_WORD_W-1:0] r_mem [DEPTH];
  logic [AW:0]            r_wptr;
  logic [AW:0]            r_rptr;

  // Storage has no reset; only the pointers define what is valid. When full
  // with a simultaneous pop, the write lands in the slot being popped, which
  // is safe because the head was already read this cycle.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  assign o_level = r_wptr - r_rptr;
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head  = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/trng_word_arbiter.sv
// trng_word_arbiter
// Sequences the trng_parallel32 generator (reset, seeding, warm-up discard),
// buffers its words in trng_word_fifo and hands each word to exactly one of
// NUM_REQ consumers with round-robin arbitration.
// Ports:
//   clk   single clock
//   rst   synchronous active-high reset; restarts the whole sequence
//   bus   trng_word_arbiter_if.master (generator and consumer signals)
// Optional feature macro: TRNG_HEALTH_EN enables a repetition-count test on
// pushed words that latches a sticky fault (ST_FAULT) until rst.
module trng_word_arbiter
  import trng_ctrl_pkg::*;
#(
  parameter int                     NUM_REQ       = 4,
  parameter int                     FIFO_DEPTH    = 4,
  parameter int                     WARMUP_CYCLES = 300,
  parameter logic [TRNG_WORD_W-1:0] SEED_D1       = SEED_D1_DEFAULT,
  parameter logic [TRNG_WORD_W-1:0] SEED_D2       = SEED_D2_DEFAULT,
  parameter logic [TRNG_D3_W-1:0]   SEED_D3       = SEED_D3_DEFAULT,
  parameter int                     RCT_LIMIT     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  trng_word_arbiter_if.master  bus
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = (WARMUP_CYCLES < 2) ? 1 : $clog2(WARMUP_CYCLES);
  localparam logic [PW:0]   NREQ      = (PW+1)'(NUM_REQ);
  localparam logic [PW-1:0] LAST_REQ  = PW'(NUM_REQ - 1);
  localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP_CYCLES - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("trng_word_arbiter: NUM_REQ must be 2..8");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("trng_word_arbiter: FIFO_DEPTH must be a power of 2, at least 2");
  end
  if (RCT_LIMIT < 2) begin : g_bad_rct
    $error("trng_word_arbiter: RCT_LIMIT must be at least 2");
  end

  trng_ctrl_state_e   r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_trng_rst;
  logic               r_ready;
  logic [PW-1:0]      r_ptr;
  logic [15:0]        r_drop_cnt;

  logic               w_run;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic               w_flush;
  logic               w_full;
  logic               w_empty;
  logic [LW-1:0]      w_level;
  logic [TRNG_WORD_W-1:0] w_head;

  logic [PW:0]        w_idx;
  logic [PW-1:0]      w_winner;
  logic [PW-1:0]      w_ptr_next;
  logic               w_found;
  logic [NUM_REQ-1:0] w_gnt;

  assign w_run = (r_state == ST_RUN);

  // Round-robin search starting at r_ptr and wrapping modulo NUM_REQ; a grant
  // is only possible while running with at least one buffered word.
  always_comb begin
    w_gnt    = '0;
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    if (w_run && !w_empty) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        w_idx = {1'b0, r_ptr} + (PW+1)'(i);
        if (w_idx >= NREQ) w_idx = w_idx - NREQ;
        if (!w_found && bus.req[w_idx[PW-1:0]]) begin
          w_found  = 1'b1;
          w_winner = w_idx[PW-1:0];
        end
      end
      if (w_found) w_gnt[w_winner] = 1'b1;
    end
  end

  assign w_ptr_next = (w_winner == LAST_REQ) ? '0 : w_winner + 1'b1;
  assign w_pop      = w_found;

  // A word is taken when there is room, counting the slot freed by a
  // same-cycle pop; otherwise it is lost and counted.
  assign w_accept = w_run && bus.trng_word_valid && (!w_full || w_pop);
  assign w_drop   = w_run && bus.trng_word_valid && w_full && !w_pop;

`ifdef TRNG_HEALTH_EN
  localparam int RCW = $clog2(RCT_LIMIT + 1);
  localparam logic [RCW-1:0] RCT_TRIP = RCW'(RCT_LIMIT - 1);

  logic [TRNG_WORD_W-1:0] r_last_word;
  logic [RCW-1:0]         r_rep_cnt;
  logic                   r_fault;
  logic                   w_same;
  logic                   w_rct_trip;

  // r_rep_cnt is the length of the current run of identical pushed words
  // (0 = nothing pushed yet). The word that would complete a run of
  // RCT_LIMIT is never pushed.
  assign w_same     = (r_rep_cnt != '0) && (bus.trng_rand_word == r_last_word);
  assign w_rct_trip = w_accept && w_same && (r_rep_cnt == RCT_TRIP);
  assign w_push     = w_accept && !w_rct_trip;
  assign w_flush    = w_rct_trip || (r_state == ST_FAULT);
`else
  assign w_push  = w_accept;
  assign w_flush = 1'b0;
`endif

  trng_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (bus.trng_rand_word),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level),
    .o_head  (w_head)
  );

  // Sequencer: hold the generator in reset for two cycles, discard
  // WARMUP_CYCLES cycles of output, then run. Status outputs are registered
  // alongside the state so they change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_TRNG_RST;
      r_cnt      <= '0;
      r_trng_rst <= 1'b1;
      r_ready    <= 1'b0;
      r_ptr      <= '0;
      r_drop_cnt <= '0;
`ifdef TRNG_HEALTH_EN
      r_last_word <= '0;
      r_rep_cnt   <= '0;
      r_fault     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_TRNG_RST: begin
          if (r_cnt == CW'(1)) begin
            r_state    <= ST_WARMUP;
            r_cnt      <= '0;
            r_trng_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WARMUP: begin
          if (r_cnt == WARM_LAST) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (w_pop) r_ptr <= w_ptr_next;
          if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 1'b1;
`ifdef TRNG_HEALTH_EN
          if (w_rct_trip) begin
            r_state <= ST_FAULT;
            r_ready <= 1'b0;
            r_fault <= 1'b1;
          end else if (w_push) begin
            r_last_word <= bus.trng_rand_word;
            r_rep_cnt   <= w_same ? r_rep_cnt + 1'b1 : RCW'(1);
          end
`endif
        end
`ifdef TRNG_HEALTH_EN
        ST_FAULT: begin
          r_state <= ST_FAULT;
        end
`endif
        default: begin
          r_state <= ST_TRNG_RST;
        end
      endcase
    end
  end

  assign bus.trng_rst   = r_trng_rst;
  assign bus.trng_d1    = SEED_D1;
  assign bus.trng_d2    = SEED_D2;
  assign bus.trng_d3    = SEED_D3;
  assign bus.gnt        = w_gnt;
  assign bus.rdata      = w_head;
  assign bus.ready      = r_ready;
  assign bus.fifo_level = w_level;
  assign bus.drop_cnt   = r_drop_cnt;
`ifdef TRNG_HEALTH_EN
  assign bus.fault      = r_fault;
`else
  assign bus.fault      = 1'b0;
`endif

endmodule

// File: tb/tb_trng_word_arbiter.sv
// tb_trng_word_arbiter
// Directed bench for trng_word_arbiter with NUM_REQ=4, FIFO_DEPTH=4 and
// WARMUP_CYCLES=300. Inputs change 1 time unit after the rising edge and
// outputs are compared a few units later, well before the next edge.
// Optional feature macro: TRNG_HEALTH_EN selects the fault expectations.
module tb_trng_word_arbiter;
  import trng_ctrl_pkg::*;

  localparam int          WARMUP = 300;
  localparam logic [31:0] BASE   = 32'hA000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  trng_word_arbiter_if #(.NUM_REQ(4), .FIFO_DEPTH(4)) bus ();

  trng_word_arbiter #(
    .NUM_REQ       (4),
    .FIFO_DEPTH    (4),
    .WARMUP_CYCLES (WARMUP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset state and constant seed outputs.
  task automatic test_reset;
    rst = 1'b1;
    bus.trng_word_valid = 1'b0;
    bus.trng_rand_word  = '0;
    bus.req             = '0;
    repeat (3) tick;
    bus.req = 4'b1111;
    #2;
    vectors++; if (bus.trng_rst !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_trng_rst: got %0h expected 1", bus.trng_rst); end
    vectors++; if (bus.gnt !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_gnt: got %b expected 0000", bus.gnt); end
    vectors++; if (bus.ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready: got %0h expected 0", bus.ready); end
    vectors++; if (bus.fault !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_fault: got %0h expected 0", bus.fault); end
    vectors++; if (bus.fifo_level !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_level: got %0d expected 0", bus.fifo_level); end
    vectors++; if (bus.drop_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_drop: got %0d expected 0", bus.drop_cnt); end
    vectors++; if (bus.trng_d1 !== 32'hAAAAAAAA) begin miscompares++; $display("[TB] FAIL seed_d1: got %h expected aaaaaaaa", bus.trng_d1); end
    vectors++; if (bus.trng_d2 !== 32'h55555555) begin miscompares++; $display("[TB] FAIL seed_d2: got %h expected 55555555", bus.trng_d2); end
    vectors++; if (bus.trng_d3 !== 5'b10101) begin miscompares++; $display("[TB] FAIL seed_d3: got %b expected 10101", bus.trng_d3); end
    bus.req = '0;
  endtask

  // One-cycle reset, then the full startup with a word offered every cycle.
  task automatic test_startup;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int c = 0; c <= WARMUP + 2; c++) begin
      bus.trng_word_valid = 1'b1;
      bus.trng_rand_word  = BASE + 32'(c);
      bus.req             = '0;
      #2;
      vectors++; if (bus.trng_rst !== (c < 2)) begin miscompares++; $display("[TB] FAIL startup_trng_rst c=%0d: got %0h expected %0h", c, bus.trng_rst, (c < 2)); end
      vectors++; if (bus.ready !== (c >= WARMUP + 2)) begin miscompares++; $display("[TB] FAIL startup_ready c=%0d: got %0h expected %0h", c, bus.ready, (c >= WARMUP + 2)); end
      vectors++; if (bus.fifo_level !== 3'd0) begin miscompares++; $display("[TB] FAIL startup_level c=%0d: got %0d expected 0", c, bus.fifo_level); end
      if (c == 0) begin
        vectors++; if (bus.drop_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL startup_drop: got %0d expected 0", bus.drop_cnt); end
      end
      tick;
    end
    bus.trng_word_valid = 1'b0;
    bus.req             = 4'b1000;
    #2;
    vectors++; if (bus.fifo_level !== 3'd1) begin miscompares++; $display("[TB] FAIL startup_first_level: got %0d expected 1", bus.fifo_level); end
    vectors++; if (bus.gnt !== 4'b1000) begin miscompares++; $display("[TB] FAIL startup_first_gnt: got %b expected 1000", bus.gnt); end
    vectors++; if (bus.rdata !== BASE + 32'(WARMUP + 2)) begin miscompares++; $display("[TB] FAIL startup_first_word: got %h expected %h", bus.rdata, BASE + 32'(WARMUP + 2)); end
    tick;
    bus.req = 4'b1111;
    #2;
    vectors++; if (bus.fifo_level !== 3'd0) begin miscompares++; $display("[TB] FAIL startup_drained: got %0d expected 0", bus.fifo_level); end
    vectors++; if (bus.gnt !== 4'b0000) begin miscompares++; $display("[TB] FAIL startup_empty_gnt: got %b expected 0000", bus.gnt); end
    bus.req = '0;
  endtask

  // All four consumers requesting with one new word per cycle.
  task automatic test_round_robin;
    logic [3:0] expGnt;
    tick;
    bus.trng_word_valid = 1'b1;
    bus.trng_rand_word  = 32'hC000_0000;
    bus.req             = 4'b1111;
    #2;
    vectors++; if (bus.gnt !== 4'b0000) begin miscompares++; $display("[TB] FAIL rr_empty_gnt: got %b expected 0000", bus.gnt); end
    for (int k = 0; k < 5; k++) begin
      tick;
      bus.trng_rand_word = 32'hC000_0000 + 32'(k + 1);
      #2;
      expGnt = 4'b0001 << (k % 4);
      vectors++; if (bus.gnt !== expGnt) begin miscompares++; $display("[TB] FAIL rr_gnt k=%0d: got %b expected %b", k, bus.gnt, expGnt); end
      vectors++; if (bus.rdata !== 32'hC000_0000 + 32'(k)) begin miscompares++; $display("[TB] FAIL rr_rdata k=%0d: got %h expected %h", k, bus.rdata, 32'hC000_0000 + 32'(k)); end
      vectors++; if (bus.fifo_level !== 3'd1) begin miscompares++; $display("[TB] FAIL rr_level k=%0d: got %0d expected 1", k, bus.fifo_level); end
    end
    tick;
    bus.trng_word_valid = 1'b0;
    #2;
    vectors++; if (bus.gnt !== 4'b0010) begin miscompares++; $display("[TB] FAIL rr_tail_gnt: got %b expected 0010", bus.gnt); end
    vectors++; if (bus.rdata !== 32'hC000_0005) begin miscompares++; $display("[TB] FAIL rr_tail_rdata: got %h expected c0000005", bus.rdata); end
    tick;
    bus.req = '0;
    #2;
    vectors++; if (bus.fifo_level !== 3'd0) begin miscompares++; $display("[TB] FAIL rr_drained: got %0d expected 0", bus.fifo_level); end
  endtask

  // Six words into a depth-4 FIFO with nobody requesting.
  task automatic test_overflow;
    for (int k = 0; k < 6; k++) begin
      tick;
      bus.trng_word_valid = 1'b1;
      bus.trng_rand_word  = 32'hD000_0000 + 32'(k);
      bus.req             = '0;
      #2;
      vectors++; if (bus.fifo_level !== 3'((k < 4) ? k : 4)) begin miscompares++; $display("[TB] FAIL ovf_fill k=%0d: got %0d expected %0d", k, bus.fifo_level, (k < 4) ? k : 4); end
    end
    tick;
    bus.trng_word_valid = 1'b0;
    #2;
    vectors++; if (bus.fifo_level !== 3'd4) begin miscompares++; $display("[TB] FAIL ovf_level: got %0d expected 4", bus.fifo_level); end
    vectors++; if (bus.drop_cnt !== 16'd2) begin miscompares++; $display("[TB] FAIL ovf_drop: got %0d expected 2", bus.drop_cnt); end
    for (int k = 0; k < 4; k++) begin
      bus.req = 4'b0001;
      #1;
      vectors++; if (bus.gnt !== 4'b0001) begin miscompares++; $display("[TB] FAIL ovf_drain_gnt k=%0d: got %b expected 0001", k, bus.gnt); end
      vectors++; if (bus.rdata !== 32'hD000_0000 + 32'(k)) begin miscompares++; $display("[TB] FAIL ovf_drain_rdata k=%0d: got %h expected %h", k, bus.rdata, 32'hD000_0000 + 32'(k)); end
      tick;
    end
    bus.req = '0;
    #1;
    vectors++; if (bus.fifo_level !== 3'd0) begin miscompares++; $display("[TB] FAIL ovf_drained: got %0d expected 0", bus.fifo_level); end
  endtask

  // Full FIFO: a push in the same cycle as a grant must be accepted.
  task automatic test_full_push_pop;
    for (int k = 0; k < 4; k++) begin
      tick;
      bus.trng_word_valid = 1'b1;
      bus.trng_rand_word  = 32'hE000_0000 + 32'(k);
      bus.req             = '0;
    end
    tick;
    bus.trng_rand_word = 32'hE000_0004;
    bus.req            = 4'b0001;
    #2;
    vectors++; if (bus.fifo_level !== 3'd4) begin miscompares++; $display("[TB] FAIL fpp_full: got %0d expected 4", bus.fifo_level); end
    vectors++; if (bus.gnt !== 4'b0001) begin miscompares++; $display("[TB] FAIL fpp_gnt: got %b expected 0001", bus.gnt); end
    vectors++; if (bus.rdata !== 32'hE000_0000) begin miscompares++; $display("[TB] FAIL fpp_rdata: got %h expected e0000000", bus.rdata); end
    tick;
    bus.trng_word_valid = 1'b0;
    bus.req             = '0;
    #2;
    vectors++; if (bus.fifo_level !== 3'd4) begin miscompares++; $display("[TB] FAIL fpp_level: got %0d expected 4", bus.fifo_level); end
    vectors++; if (bus.drop_cnt !== 16'd2) begin miscompares++; $display("[TB] FAIL fpp_drop: got %0d expected 2", bus.drop_cnt); end
    for (int k = 1; k <= 4; k++) begin
      bus.req = 4'b0001;
      #1;
      vectors++; if (bus.rdata !== 32'hE000_0000 + 32'(k)) begin miscompares++; $display("[TB] FAIL fpp_drain k=%0d: got %h expected %h", k, bus.rdata, 32'hE000_0000 + 32'(k)); end
      tick;
    end
    bus.req = '0;
    #1;
    vectors++; if (bus.fifo_level !== 3'd0) begin miscompares++; $display("[TB] FAIL fpp_drained: got %0d expected 0", bus.fifo_level); end
  endtask

  // Three buffered words, then a one-cycle reset and a complete restart.
  task automatic test_reset_mid_run;
    for (int k = 0; k < 3; k++) begin
      tick;
      bus.trng_word_valid = 1'b1;
      bus.trng_rand_word  = 32'hF000_0000 + 32'(k);
      bus.req             = '0;
    end
    tick;
    bus.trng_word_valid = 1'b0;
    #2;
    vectors++; if (bus.fifo_level !== 3'd3) begin miscompares++; $display("[TB] FAIL mid_level: got %0d expected 3", bus.fifo_level); end
    vectors++; if (bus.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_ready: got %0h expected 1", bus.ready); end
    test_startup();
  endtask

  // Three identical consecutive words.
  task automatic test_health;
    for (int k = 0; k < 3; k++) begin
      tick;
      bus.trng_word_valid = 1'b1;
      bus.trng_rand_word  = 32'hDEADBEEF;
      bus.req             = '0;
      #2;
      vectors++; if (bus.fifo_level !== 3'(k)) begin miscompares++; $display("[TB] FAIL rct_fill k=%0d: got %0d expected %0d", k, bus.fifo_level, k); end
    end
    tick;
    bus.trng_rand_word = 32'h1234_5678;
    bus.req            = 4'b1111;
    #2;
`ifdef TRNG_HEALTH_EN
    for (int k = 0; k < 3; k++) begin
      vectors++; if (bus.fault !== 1'b1) begin miscompares++; $display("[TB] FAIL rct_fault k=%0d: got %0h expected 1", k, bus.fault); end
      vectors++; if (bus.ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rct_ready k=%0d: got %0h expected 0", k, bus.ready); end
      vectors++; if (bus.gnt !== 4'b0000) begin miscompares++; $display("[TB] FAIL rct_gnt k=%0d: got %b expected 0000", k, bus.gnt); end
      vectors++; if (bus.fifo_level !== 3'd0) begin miscompares++; $display("[TB] FAIL rct_level k=%0d: got %0d expected 0", k, bus.fifo_level); end
      tick;
      #2;
    end
    bus.trng_word_valid = 1'b0;
    bus.req             = '0;
    rst = 1'b1;
    tick;
    tick;
    #2;
    vectors++; if (bus.fault !== 1'b0) begin miscompares++; $display("[TB] FAIL rct_cleared: got %0h expected 0", bus.fault); end
`else
    vectors++; if (bus.fault !== 1'b0) begin miscompares++; $display("[TB] FAIL rct_fault: got %0h expected 0", bus.fault); end
    vectors++; if (bus.fifo_level !== 3'd3) begin miscompares++; $display("[TB] FAIL rct_level: got %0d expected 3", bus.fifo_level); end
    vectors++; if (bus.gnt !== 4'b0001) begin miscompares++; $display("[TB] FAIL rct_gnt: got %b expected 0001", bus.gnt); end
    vectors++; if (bus.rdata !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL rct_rdata: got %h expected deadbeef", bus.rdata); end
    bus.trng_word_valid = 1'b0;
    bus.req             = '0;
`endif
  endtask

  initial begin
    $display("[TB] starting trng_word_arbiter directed tests");
    test_reset();
    test_startup();
    test_round_robin();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_run();
    test_health();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
